div_trad: RTL

- Sequential restoring divider, one quotient bit per clock.
- Unsigned w-bit dividend, unsigned w-bit divisor; produces a w-bit quotient and a w-bit remainder.
- Serves as the divide counterpart to the team's shift-add serial multiplier, for low-area datapaths that can tolerate w-cycle latency, e.g. gain normalisation and ratio computation.
- Uses the same load / prestrobe / strobe timing idiom as the multiplier.

---
 rtl/div_trad_if.sv | 25 ++
 rtl/div_trad.sv | 117 +++++++++++
 2 files changed

// File: rtl/div_trad_if.sv
// Operand/result bundle for the serial divider: loads flow master->slave, results and timing pulses back.
// No backpressure; load restarts the slave unconditionally.
interface div_trad_if #(
    parameter int w = 16
);
    logic         load;
    logic [w-1:0] N;
    logic [w-1:0] D;
    logic [w-1:0] Q;
    logic [w-1:0] R;
    logic         dz;
    logic         busy;
    logic         prestrobe;
    logic         strobe;

    modport master (
        output load, N, D,
        input  Q, R, dz, busy, prestrobe, strobe
    );

    modport slave (
        input  load, N, D,
        output Q, R, dz, busy, prestrobe, strobe
    );
endinterface

// File: rtl/div_trad.sv
// Restoring serial divider, one quotient bit per clock; result strobes w edges after load.
// No backpressure: load is always accepted and aborts any operation in flight.
module div_trad #(
    parameter int w = 16
) (
    input  logic        clk,
    input  logic        rst,
    div_trad_if.slave   bus
);
    localparam int CW = $clog2(w + 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t        state_q, state_d;
    // The partial remainder is always below the divisor after each step, so its top bit is never set
    // and only w bits need to be stored.
    logic [w-1:0]  p_q, p_d;
    logic [w-1:0]  s_q, s_d;
    logic [w-1:0]  dr_q, dr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          dz_pend_q, dz_pend_d;
    logic [w-1:0]  q_q, q_d;
    logic [w-1:0]  r_q, r_d;
    logic          dz_q, dz_d;
    logic          strobe_q, strobe_d;
    logic          prestrobe_q, prestrobe_d;

    logic [w:0]    shifted;
    logic [w:0]    trial;

    always_comb begin
        shifted     = {p_q, s_q[w-1]};
        trial       = shifted - {1'b0, dr_q};

        state_d     = state_q;
        p_d         = p_q;
        s_d         = s_q;
        dr_d        = dr_q;
        cnt_d       = cnt_q;
        dz_pend_d   = dz_pend_q;
        q_d         = q_q;
        r_d         = r_q;
        dz_d        = dz_q;
        strobe_d    = 1'b0;
        prestrobe_d = 1'b0;

        if (bus.load) begin
            state_d   = ST_RUN;
            p_d       = '0;
            s_d       = bus.N;
            dr_d      = bus.D;
            cnt_d     = CW'(w);
            dz_pend_d = (bus.D == '0);
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!trial[w]) begin
                        p_d = trial[w-1:0];
                        s_d = {s_q[w-2:0], 1'b1};
                    end else begin
                        p_d = shifted[w-1:0];
                        s_d = {s_q[w-2:0], 1'b0};
                    end
                    cnt_d       = cnt_q - 1'b1;
                    prestrobe_d = (cnt_q == CW'(2));
                    // The final step's result is captured straight into the output registers.
                    if (cnt_q == CW'(1)) begin
                        state_d  = ST_IDLE;
                        q_d      = s_d;
                        r_d      = p_d;
                        dz_d     = dz_pend_q;
                        strobe_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            p_q         <= '0;
            s_q         <= '0;
            dr_q        <= '0;
            cnt_q       <= '0;
            dz_pend_q   <= 1'b0;
            q_q         <= '0;
            r_q         <= '0;
            dz_q        <= 1'b0;
            strobe_q    <= 1'b0;
            prestrobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            p_q         <= p_d;
            s_q         <= s_d;
            dr_q        <= dr_d;
            cnt_q       <= cnt_d;
            dz_pend_q   <= dz_pend_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dz_q        <= dz_d;
            strobe_q    <= strobe_d;
            prestrobe_q <= prestrobe_d;
        end
    end

    assign bus.Q         = q_q;
    assign bus.R         = r_q;
    assign bus.dz        = dz_q;
    assign bus.busy      = (state_q == ST_RUN);
    assign bus.strobe    = strobe_q;
    assign bus.prestrobe = prestrobe_q;
endmodule
